btb_assoc: RTL and testbench

- Parametrised set-associative branch target buffer; successor to the direct-mapped BTB controller.
- Sits beside fetch. Lookup takes the fetch PC and returns a registered hit/taken/target prediction one cycle later.
- Update takes resolved-branch info from execute and trains a per-entry 2-bit saturating direction counter.
- Adds tags, valid bits, multi-way allocation, and a sequenced flush.

---
 rtl/btb_assoc_pkg.sv | 40 ++++
 rtl/btb_assoc_if.sv | 43 ++++
 rtl/btb_assoc_sat_ctr2.sv | 18 +
 rtl/btb_assoc.sv | 225 ++++++++++++++++++++++
 tb/tb_btb_assoc.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/btb_assoc_pkg.sv
// Shared types for the set-associative branch target buffer.
// Package name is "core" so other front-end blocks can share the same types.
package core;

    localparam int ADDR_WIDTH = 32;
    localparam int BTB_SIZE   = 64;
    localparam int BTB_WAYS   = 2;

    // Flush sequencer states; exported on the debug port of the BTB.
    typedef enum logic {
        FL_IDLE  = 1'b0,
        FL_FLUSH = 1'b1
    } flush_state_t;

    // One BTB way. The tag field is full width so the type does not depend on
    // the instance geometry; the unused upper tag bits are always zero.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] tag;
        logic [ADDR_WIDTH-1:0] target;
        logic [1:0]            ctr;
    } btb_way_t;

    // Resolved-branch training bundle coming from execute.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  is_branch;
        logic                  taken;
        logic [ADDR_WIDTH-1:0] target;
    } btb_upd_t;

    // Prediction bundle handed back to fetch.
    typedef struct packed {
        logic                  hit;
        logic                  taken;
        logic [ADDR_WIDTH-1:0] target;
    } br_cntrl_bus_t;

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch/execute facing bus of the BTB. master = core side, slave = BTB.
// Handshake: every request (lookup_valid_i, upd_valid_i, flush_i) is a
// single-cycle valid with no ready; the BTB always accepts. Lookup results
// appear on hit_o/pred_* exactly one cycle after the lookup_valid_i cycle.
// Requests during a flush (flush_busy_o=1) are dropped.
interface btb_assoc_if #(
    parameter int ADDR_WIDTH = core::ADDR_WIDTH
);
    import core::*;

    logic                  lookup_valid_i;
    logic [ADDR_WIDTH-1:0] lookup_pc_i;
    logic                  hit_o;
    logic                  pred_taken_o;
    logic [ADDR_WIDTH-1:0] pred_target_o;
    logic                  upd_valid_i;
    logic [ADDR_WIDTH-1:0] upd_pc_i;
    logic                  upd_is_branch_i;
    logic                  upd_taken_i;
    logic [ADDR_WIDTH-1:0] upd_target_i;
    logic                  flush_i;
    logic                  flush_busy_o;
    logic [31:0]           stat_lookups_o;
    logic [31:0]           stat_hits_o;
    flush_state_t          dbg_state;

    modport master (
        output lookup_valid_i, lookup_pc_i,
        output upd_valid_i, upd_pc_i, upd_is_branch_i, upd_taken_i, upd_target_i,
        output flush_i,
        input  hit_o, pred_taken_o, pred_target_o, flush_busy_o,
        input  stat_lookups_o, stat_hits_o, dbg_state
    );

    modport slave (
        input  lookup_valid_i, lookup_pc_i,
        input  upd_valid_i, upd_pc_i, upd_is_branch_i, upd_taken_i, upd_target_i,
        input  flush_i,
        output hit_o, pred_taken_o, pred_target_o, flush_busy_o,
        output stat_lookups_o, stat_hits_o, dbg_state
    );

endinterface

// File: rtl/btb_assoc_sat_ctr2.sv
// 2-bit saturating up/down direction counter, next-state only.
module sat_ctr2 (
    input  logic [1:0] ctr_i,
    input  logic       up_i,
    output logic [1:0] ctr_o
);

    // Step toward 3 on taken, toward 0 on not-taken, holding at the ends.
    always_comb begin
        ctr_o = ctr_i;
        if (up_i && ctr_i != 2'b11) begin
            ctr_o = ctr_i + 2'b01;
        end else if (!up_i && ctr_i != 2'b00) begin
            ctr_o = ctr_i - 2'b01;
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with registered lookup, per-entry
// 2-bit direction counters, round-robin replacement and a one-set-per-cycle
// flush sequencer.
// Optional macro BTB_STATS_EN: adds 32-bit lookup/hit counters; when it is
// undefined the stat ports are tied to zero.
module btb_assoc
    import core::*;
#(
    parameter int         ADDR_WIDTH = core::ADDR_WIDTH,
    parameter int         ENTRIES    = core::BTB_SIZE,
    parameter int         WAYS       = core::BTB_WAYS,
    parameter logic [1:0] CNT_INIT   = 2'b10
) (
    input logic        clk,
    input logic        rst,
    btb_assoc_if.slave bus
);

    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PW    = core::ADDR_WIDTH;

    // Valid bits and replacement pointers are reset; payload arrays are not.
    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [WAY_W-1:0]          rr_q     [SETS];
    logic [TAG_W-1:0]          tag_q    [SETS][WAYS];
    logic [ADDR_WIDTH-1:0]     target_q [SETS][WAYS];
    logic [1:0]                ctr_q    [SETS][WAYS];

    flush_state_t   state_q, state_d;
    logic [IDX-1:0] fset_q, fset_d;
    logic           flushing;

    assign flushing = (state_q == FL_FLUSH);

    // ---------------- lookup ----------------
    logic [IDX-1:0]        lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    btb_way_t [WAYS-1:0]   lk_way;
    br_cntrl_bus_t         pred_d, pred_q;

    assign lk_idx = bus.lookup_pc_i[IDX+1:2];
    assign lk_tag = bus.lookup_pc_i[ADDR_WIDTH-1:IDX+2];

    // Assemble the ways of the looked-up set (pre-update contents).
    always_comb begin
        lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            lk_way[w].valid  = valid_q[lk_idx][w];
            lk_way[w].tag    = PW'(tag_q[lk_idx][w]);
            lk_way[w].target = PW'(target_q[lk_idx][w]);
            lk_way[w].ctr    = ctr_q[lk_idx][w];
        end
    end

    // Pick the matching way; scanning downward lets the lowest way win.
    always_comb begin
        pred_d = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_way[w].valid && lk_way[w].tag == PW'(lk_tag)) begin
                pred_d.hit    = 1'b1;
                pred_d.taken  = lk_way[w].ctr[1];
                pred_d.target = lk_way[w].target;
            end
        end
        if (!bus.lookup_valid_i || flushing) begin
            pred_d = '0;
        end
    end

    // Register the prediction for the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pred_q <= '0;
        else     pred_q <= pred_d;
    end

    assign bus.hit_o         = pred_q.hit;
    assign bus.pred_taken_o  = pred_q.taken;
    assign bus.pred_target_o = pred_q.target[ADDR_WIDTH-1:0];

    // ---------------- update ----------------
    btb_upd_t         upd;
    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit, up_free;
    logic [WAY_W-1:0] up_hit_way, up_free_way, alloc_way;
    logic             upd_en, do_train, do_alloc;
    logic [1:0]       ctr_nxt [WAYS];

    assign upd.valid     = bus.upd_valid_i;
    assign upd.pc        = PW'(bus.upd_pc_i);
    assign upd.is_branch = bus.upd_is_branch_i;
    assign upd.taken     = bus.upd_taken_i;
    assign upd.target    = PW'(bus.upd_target_i);

    assign up_idx = upd.pc[IDX+1:2];
    assign up_tag = upd.pc[ADDR_WIDTH-1:IDX+2];

    // Find the hitting way and the lowest invalid way of the update set.
    always_comb begin
        up_hit      = 1'b0;
        up_hit_way  = '0;
        up_free     = 1'b0;
        up_free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
                up_hit     = 1'b1;
                up_hit_way = WAY_W'(w);
            end
            if (!valid_q[up_idx][w]) begin
                up_free     = 1'b1;
                up_free_way = WAY_W'(w);
            end
        end
    end

    assign alloc_way = up_free ? up_free_way : rr_q[up_idx];
    assign upd_en    = upd.valid && upd.is_branch && !flushing;
    assign do_train  = upd_en && up_hit;
    assign do_alloc  = upd_en && !up_hit && upd.taken;

    for (genvar g = 0; g < WAYS; g++) begin : g_ctr
        sat_ctr2 u_ctr (
            .ctr_i (ctr_q[up_idx][g]),
            .up_i  (upd.taken),
            .ctr_o (ctr_nxt[g])
        );
    end

    // Payload write: train counter/target on hit, fill entry on taken miss.
    always_ff @(posedge clk) begin
        if (do_train) begin
            ctr_q[up_idx][up_hit_way] <= ctr_nxt[up_hit_way];
            if (upd.taken) begin
                target_q[up_idx][up_hit_way] <= upd.target[ADDR_WIDTH-1:0];
            end
        end else if (do_alloc) begin
            tag_q[up_idx][alloc_way]    <= up_tag;
            target_q[up_idx][alloc_way] <= upd.target[ADDR_WIDTH-1:0];
            ctr_q[up_idx][alloc_way]    <= CNT_INIT;
        end
    end

    // Valid bits and round-robin pointers: flush sweep has priority over fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (flushing) begin
            valid_q[fset_q] <= '0;
        end else if (do_alloc) begin
            valid_q[up_idx][alloc_way] <= 1'b1;
            if (!up_free) begin
                rr_q[up_idx] <= (rr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                    : rr_q[up_idx] + 1'b1;
            end
        end
    end

    // ---------------- flush FSM ----------------
    // State register and set counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FL_IDLE;
            fset_q  <= '0;
        end else begin
            state_q <= state_d;
            fset_q  <= fset_d;
        end
    end

    // Next state: one set per cycle, leave after the last set is cleared.
    always_comb begin
        state_d = state_q;
        fset_d  = fset_q;
        case (state_q)
            FL_IDLE: begin
                if (bus.flush_i) begin
                    state_d = FL_FLUSH;
                    fset_d  = '0;
                end
            end
            FL_FLUSH: begin
                fset_d = fset_q + 1'b1;
                if (fset_q == IDX'(SETS - 1)) state_d = FL_IDLE;
            end
            default: state_d = FL_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.flush_busy_o = (state_q == FL_FLUSH);
        bus.dbg_state    = state_q;
    end

    // ---------------- statistics ----------------
`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, hits_q;

    // Count accepted lookups and the hits registered from them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            if (bus.lookup_valid_i && !flushing) lookups_q <= lookups_q + 32'd1;
            if (pred_d.hit)                      hits_q    <= hits_q + 32'd1;
        end
    end

    assign bus.stat_lookups_o = lookups_q;
    assign bus.stat_hits_o    = hits_q;
`else
    assign bus.stat_lookups_o = '0;
    assign bus.stat_hits_o    = '0;
`endif

    // Byte-offset bits and the lookup counter LSB are not needed.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.lookup_pc_i[1:0], upd.pc[1:0], ^lk_way};

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (ENTRIES=64, WAYS=2, 32 sets).
module tb_btb_assoc;
    import core::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    btb_assoc_if #(.ADDR_WIDTH(32)) bus ();

    btb_assoc #(
        .ADDR_WIDTH (32),
        .ENTRIES    (64),
        .WAYS       (2),
        .CNT_INIT   (2'b10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard: {hit, taken, target} expected one cycle after each lookup.
    logic [33:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int exp_lk = 0;
    int exp_hit = 0;

    logic [31:0] rpc [4];
    logic [31:0] rtg [4];
    int busy_cycles;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string name);
        logic [33:0] e;
        chk({name, "_q"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(name, {30'd0, bus.hit_o, bus.pred_taken_o, bus.pred_target_o}, {30'd0, e});
        end
    endtask

    task automatic lookup_chk(input string name, input logic [31:0] pc,
                              input logic eh, input logic et, input logic [31:0] etg);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = pc;
        exp_q.push_back({eh, et, etg});
        exp_lk++;
        if (eh) exp_hit++;
        tick();
        bus.lookup_valid_i = 1'b0;
        pop_chk(name);
    endtask

    task automatic update(input logic [31:0] pc, input logic is_br,
                          input logic taken, input logic [31:0] tgt);
        bus.upd_valid_i     = 1'b1;
        bus.upd_pc_i        = pc;
        bus.upd_is_branch_i = is_br;
        bus.upd_taken_i     = taken;
        bus.upd_target_i    = tgt;
        tick();
        bus.upd_valid_i     = 1'b0;
    endtask

    initial begin
        bus.lookup_valid_i  = 1'b0;
        bus.lookup_pc_i     = '0;
        bus.upd_valid_i     = 1'b0;
        bus.upd_pc_i        = '0;
        bus.upd_is_branch_i = 1'b0;
        bus.upd_taken_i     = 1'b0;
        bus.upd_target_i    = '0;
        bus.flush_i         = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hit", 64'(bus.hit_o), 64'd0);
        chk("rst_taken", 64'(bus.pred_taken_o), 64'd0);
        chk("rst_target", 64'(bus.pred_target_o), 64'd0);
        chk("rst_busy", 64'(bus.flush_busy_o), 64'd0);
        chk("rst_state", 64'(bus.dbg_state), 64'(FL_IDLE));
        rst = 1'b0;
        tick();

        // Cold miss, then allocate and hit with weakly-taken counter.
        lookup_chk("cold_miss", 32'h100, 1'b0, 1'b0, 32'h0);
        update(32'h100, 1'b1, 1'b1, 32'h400);
        lookup_chk("alloc_hit", 32'h100, 1'b1, 1'b1, 32'h400);

        // Not-taken training down to 0 and saturation there.
        update(32'h100, 1'b1, 1'b0, 32'hdead);
        lookup_chk("ctr1", 32'h100, 1'b1, 1'b0, 32'h400);
        update(32'h100, 1'b1, 1'b0, 32'hdead);
        update(32'h100, 1'b1, 1'b0, 32'hdead);
        lookup_chk("ctr0_sat", 32'h100, 1'b1, 1'b0, 32'h400);
        update(32'h100, 1'b1, 1'b1, 32'h400);
        lookup_chk("ctr_after_sat0", 32'h100, 1'b1, 1'b0, 32'h400);
        update(32'h100, 1'b1, 1'b1, 32'h440);
        lookup_chk("tgt_overwrite", 32'h100, 1'b1, 1'b1, 32'h440);

        // Saturation at 3: two more taken, one not-taken leaves counter at 2.
        update(32'h100, 1'b1, 1'b1, 32'h440);
        update(32'h100, 1'b1, 1'b1, 32'h440);
        update(32'h100, 1'b1, 1'b0, 32'h440);
        lookup_chk("ctr3_sat", 32'h100, 1'b1, 1'b1, 32'h440);

        // Non-branch and not-taken misses allocate nothing.
        update(32'h900, 1'b0, 1'b1, 32'h999);
        lookup_chk("non_branch", 32'h900, 1'b0, 1'b0, 32'h0);
        update(32'h980, 1'b1, 1'b0, 32'h999);
        lookup_chk("nt_miss", 32'h980, 1'b0, 1'b0, 32'h0);

        // Set 0 conflict: second way fills, third evicts via round-robin.
        update(32'h200, 1'b1, 1'b1, 32'h222);
        update(32'h300, 1'b1, 1'b1, 32'h333);
        lookup_chk("evict_200", 32'h200, 1'b1, 1'b1, 32'h222);
        lookup_chk("evict_300", 32'h300, 1'b1, 1'b1, 32'h333);
        lookup_chk("evict_100", 32'h100, 1'b0, 1'b0, 32'h0);
        update(32'h100, 1'b1, 1'b1, 32'h111);
        lookup_chk("rr_adv_200", 32'h200, 1'b0, 1'b0, 32'h0);
        lookup_chk("rr_adv_300", 32'h300, 1'b1, 1'b1, 32'h333);
        lookup_chk("rr_adv_100", 32'h100, 1'b1, 1'b1, 32'h111);

        // Same-cycle lookup and update: lookup sees old contents.
        bus.lookup_valid_i  = 1'b1;
        bus.lookup_pc_i     = 32'h500;
        bus.upd_valid_i     = 1'b1;
        bus.upd_pc_i        = 32'h500;
        bus.upd_is_branch_i = 1'b1;
        bus.upd_taken_i     = 1'b1;
        bus.upd_target_i    = 32'h5a0;
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        exp_lk++;
        tick();
        bus.lookup_valid_i = 1'b0;
        bus.upd_valid_i    = 1'b0;
        pop_chk("rbw_same_cycle");
        lookup_chk("rbw_next", 32'h500, 1'b1, 1'b1, 32'h5a0);

        // Random fills into distinct sets 8..11.
        for (int k = 0; k < 4; k++) begin
            rpc[k] = ($urandom_range(1, 1 << 20) << 7) | ((8 + k) << 2);
            rtg[k] = $urandom & 32'hffff_fffc;
            update(rpc[k], 1'b1, 1'b1, rtg[k]);
        end
        for (int k = 0; k < 4; k++) begin
            lookup_chk("rand_hit", rpc[k], 1'b1, 1'b1, rtg[k]);
        end

        // Flush: busy exactly 32 cycles, lookups miss, update dropped,
        // re-asserted flush_i ignored.
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("flush_busy_start", 64'(bus.flush_busy_o), 64'd1);
        busy_cycles = 0;
        while (bus.flush_busy_o === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            bus.lookup_valid_i = 1'b1;
            bus.lookup_pc_i    = 32'h300;
            if (busy_cycles == 3) begin
                bus.upd_valid_i     = 1'b1;
                bus.upd_pc_i        = 32'h700;
                bus.upd_is_branch_i = 1'b1;
                bus.upd_taken_i     = 1'b1;
                bus.upd_target_i    = 32'h777;
            end
            if (busy_cycles == 10) bus.flush_i = 1'b1;
            exp_q.push_back({1'b0, 1'b0, 32'h0});
            tick();
            bus.lookup_valid_i = 1'b0;
            bus.upd_valid_i    = 1'b0;
            bus.flush_i        = 1'b0;
            pop_chk("flush_lookup");
        end
        chk("flush_cycles", 64'(busy_cycles), 64'd32);
        lookup_chk("post_flush_300", 32'h300, 1'b0, 1'b0, 32'h0);
        lookup_chk("post_flush_500", 32'h500, 1'b0, 1'b0, 32'h0);
        lookup_chk("post_flush_700", 32'h700, 1'b0, 1'b0, 32'h0);
        lookup_chk("post_flush_rand", rpc[2], 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a flush.
        update(32'h604, 1'b1, 1'b1, 32'h6a0);
        lookup_chk("pre_rst_hit", 32'h604, 1'b1, 1'b1, 32'h6a0);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(bus.flush_busy_o), 64'd0);
        chk("rst_mid_state", 64'(bus.dbg_state), 64'(FL_IDLE));
        tick();
        rst = 1'b0;
        exp_lk = 0;
        exp_hit = 0;
        lookup_chk("rst_mid_miss", 32'h604, 1'b0, 1'b0, 32'h0);
        update(32'h604, 1'b1, 1'b1, 32'h6b0);
        lookup_chk("rst_mid_refill", 32'h604, 1'b1, 1'b1, 32'h6b0);

`ifdef BTB_STATS_EN
        chk("stat_lookups", 64'(bus.stat_lookups_o), 64'(exp_lk));
        chk("stat_hits", 64'(bus.stat_hits_o), 64'(exp_hit));
`else
        chk("stat_lookups_tied", 64'(bus.stat_lookups_o), 64'd0);
        chk("stat_hits_tied", 64'(bus.stat_hits_o), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
